// File: rtl/alu_ctrl_stage.sv
// ============================================================================
// Module      : alu_ctrl_stage
// Description : ALU control decode plus ID/EX pipeline register with sticky
//               illegal-funct error capture.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [1:0]  aluOp,
  input  logic [5:0]  funct,
  input  logic [31:0] id_A,
  input  logic [31:0] id_B,
  input  logic        stall,
  input  logic        flush,
  input  logic        clear_err,
  output logic        ex_valid,
  output logic [3:0]  aluCtrl,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        illegal,
  output logic [5:0]  err_funct,
  output logic [7:0]  err_count
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ORI    = 2'b11;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  logic [3:0] dec_code;
  logic       dec_bad_funct;
  logic       load_en;
  logic       accept;
  logic       accept_illegal;
  logic [3:0] load_code;

  // Combinational decode from the ID-stage inputs.
  always_comb begin
    dec_code      = ALU_NOP;
    dec_bad_funct = 1'b0;
    case (aluOp)
      OP_MEM:    dec_code = ALU_ADD;
      OP_BRANCH: dec_code = ALU_SUB;
      OP_ORI:    dec_code = ALU_OR;
      OP_RTYPE: begin
        case (funct)
          6'b100000, 6'b100001: dec_code = ALU_ADD;
          6'b100010, 6'b100011: dec_code = ALU_SUB;
          6'b100100:            dec_code = ALU_AND;
          6'b100101:            dec_code = ALU_OR;
          6'b100111:            dec_code = ALU_NOR;
          6'b101010:            dec_code = ALU_SLT;
          default: begin
            dec_code      = ALU_NOP;
            dec_bad_funct = 1'b1;
          end
        endcase
      end
      default: begin
        dec_code      = ALU_NOP;
        dec_bad_funct = 1'b0;
      end
    endcase
  end

  assign load_en        = ~flush & ~stall;
  assign accept         = load_en & id_valid;
  assign accept_illegal = accept & dec_bad_funct;
  assign load_code      = id_valid ? dec_code : ALU_NOP;

  // EX pipeline register: flush beats stall beats load.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid <= 1'b0;
      aluCtrl  <= ALU_NOP;
      A        <= 32'd0;
      B        <= 32'd0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      aluCtrl  <= ALU_NOP;
      A        <= 32'd0;
      B        <= 32'd0;
    end else if (!stall) begin
      ex_valid <= id_valid;
      aluCtrl  <= load_code;
      A        <= id_A;
      B        <= id_B;
    end
  end

  // A new illegal event outranks a simultaneous clear, so the clear only
  // zeroes state when nothing illegal is being accepted this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal   <= 1'b0;
      err_funct <= 6'd0;
      err_count <= 8'd0;
    end else if (accept_illegal) begin
      illegal <= 1'b1;
      if (clear_err || !illegal) begin
        err_funct <= funct;
      end
      if (clear_err) begin
        err_count <= 8'd1;
      end else if (err_count != ERR_COUNT_MAX) begin
        err_count <= err_count + 8'd1;
      end
    end else if (clear_err) begin
      illegal   <= 1'b0;
      err_funct <= 6'd0;
      err_count <= 8'd0;
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: `clock`  in  1  rising-edge clock; `reset`  in  1  synchronous active-high reset.
REQ-002 The module SHALL have these inputs:
- `id_valid`  in  1  ID stage presents an instruction.
- `aluOp`  in  2  class from main control: 00 load/store, 01 branch, 10 R-type, 11 ori.
- `funct`  in  6  instruction bits [5:0].
- `id_A`  in  32  rs operand.
- `id_B`  in  32  rt or immediate operand.
- `stall`  in  1  hold the EX register.
- `flush`  in  1  replace the EX register with a bubble.
- `clear_err`  in  1  clear the error state.
REQ-003 The module SHALL have these outputs:
- `ex_valid`  out  1  EX slot holds a real instruction.
- `aluCtrl`  out  4  ALU operation code for the EX stage.
- `A`  out  32  registered rs operand.
- `B`  out  32  registered rt or immediate operand.
- `illegal`  out  1  sticky flag: an unsupported funct was accepted.
- `err_funct`  out  6  funct of the first illegal instruction.
- `err_count`  out  8  saturating count of illegal instructions.

Function
REQ-004 aluCtrl encoding SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NOP 1111 (1111 makes the ALU output 0).
REQ-005 Decode SHALL be: aluOp 00 -> ADD; 01 -> SUB; 11 -> OR; 10 -> by funct.
REQ-006 R-type funct map SHALL be:
- 100000/100001 -> ADD.
- 100010/100011 -> SUB.
- 100100 -> AND.
- 100101 -> OR.
- 100111 -> NOR.
- 101010 -> SLT.
- any other funct -> NOP, and the instruction is illegal.
REQ-007 Decode SHALL be combinational from ID inputs; all outputs SHALL be registered, giving latency of exactly 1 clock from ID inputs to EX outputs.
REQ-008 Per-edge priority SHALL be reset > flush > stall > load.
REQ-009 Load (no flush, no stall): ex_valid <= id_valid, aluCtrl <= decoded code (NOP if id_valid=0), A <= id_A, B <= id_B.
REQ-010 Stall (no flush): ex_valid, aluCtrl, A and B SHALL hold their values; no error update.
REQ-011 Flush: ex_valid <= 0, aluCtrl <= 1111, A <= 0, B <= 0, regardless of stall or id_valid.
REQ-012 An instruction SHALL count as accepted only on a load edge with id_valid=1.
REQ-013 Error state SHALL update only for accepted instructions with aluOp=10 and an unsupported funct.
REQ-014 On an accepted illegal instruction: illegal <= 1; err_count <= err_count+1, saturating at 255.
REQ-015 err_funct SHALL be captured only when illegal was 0 before the edge; later illegal instructions SHALL NOT overwrite it.
REQ-016 clear_err SHALL zero illegal, err_funct and err_count on the next edge.
REQ-017 If clear_err and an accepted illegal instruction occur on the same edge, the new event SHALL win: illegal=1, err_funct=new funct, err_count=1.
REQ-018 An illegal instruction SHALL still propagate to EX with ex_valid=1 and aluCtrl=1111.
REQ-019 Flushed or stalled illegal instructions SHALL NOT affect the error state.

Reset
REQ-020 Synchronous reset SHALL set ex_valid=0, aluCtrl=1111, A=0, B=0, illegal=0, err_funct=0, err_count=0.
REQ-021 Reset SHALL override flush, stall, clear_err and a pending load on the same edge.
REQ-022 Reset asserted mid-stall SHALL discard the held instruction.
REQ-023 Outputs SHALL NOT change between clock edges.

Verification
REQ-024 Decode sweep: id_valid=1 and each aluOp/funct pair in REQ-005/REQ-006, with id_A=5, id_B=3 -> after one edge, aluCtrl matches the table, A=5, B=3, ex_valid=1. Example: funct 101010 -> 0111.
REQ-025 Stall hold:
- Load ADD with A=0x10.
- Assert stall for 3 cycles while presenting SUB.
-> aluCtrl stays 0010 and A stays 0x10 for 3 cycles; SUB appears on the edge after stall drops.
REQ-026 Flush priority: flush=1 and stall=1 with a valid AND instruction -> ex_valid=0, aluCtrl=1111, A=B=0.
REQ-027 Illegal capture:
- Accept funct 000000, then funct 111111.
-> illegal=1, err_funct=000000, err_count=2, aluCtrl=1111, ex_valid=1.
- Then clear_err with an illegal instruction on the same edge -> err_count=1, err_funct=new funct.
REQ-028 Saturation and reset:
- Accept 300 illegal instructions -> err_count=255.
- Assert reset during a stall -> all outputs at REQ-020 values on the next edge.
